// File: rtl/dest_wb_pipe_pkg.sv
// dest_wb_pipe_pkg
//   Shared encodings for the writeback/forwarding path.
//   FWD_* : EX operand select driven to the EX operand muxes.
package dest_wb_pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int REG_AW_DEF = 5;

   // EX operand forward select
   localparam logic [1:0] FWD_RF = 2'b00;  // register file value
   localparam logic [1:0] FWD_W  = 2'b01;  // writeback result
   localparam logic [1:0] FWD_M  = 2'b10;  // M-stage ALU/link result

endpackage

// File: rtl/dest_wb_pipe_reg.sv
// pipe_reg
//   Parameterised pipeline register.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (clears to 0)
//   flush_i : clear to 0 (bubble)
//   stall_i : hold current value
//   d_i     : next value, captured when none of the above is active
//   q_o     : registered value
module pipe_reg #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         stall_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   // rst > flush > stall > capture
   always_comb begin
      q_d = d_i;
      if (flush_i)      q_d = '0;
      else if (stall_i) q_d = q_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) q_q <= '0;
      else       q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/dest_wb_pipe.sv
// dest_wb_pipe
//   Carries the resolved EX destination, its control bits and result through
//   the E->M and M->W pipeline registers, substitutes the link address for
//   link instructions, and produces the register-file writeback tuple.
//   Also produces forwarding selects and the load-use stall request.
//   Inputs : clk_i, rst_i, stall/flush per stage, EX dest/control/result,
//            readdataM_i, ID/EX source registers.
//   Outputs: M-stage dest/enable/result, W-stage writeback tuple,
//            forwardAE/BE (2b), forwardAD/BD, lwstallD.
module dest_wb_pipe
   import dest_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              stallM_i,
   input  logic              flushM_i,
   input  logic              stallW_i,
   input  logic              flushW_i,
   input  logic [REG_AW-1:0] writeregE_i,
   input  logic              regwriteE_i,
   input  logic              memtoregE_i,
   input  logic              linkE_i,
   input  logic [DATA_W-1:0] aluoutE_i,
   input  logic [DATA_W-1:0] pcplus8E_i,
   input  logic [DATA_W-1:0] readdataM_i,
   input  logic [REG_AW-1:0] rsD_i,
   input  logic [REG_AW-1:0] rtD_i,
   input  logic [REG_AW-1:0] rsE_i,
   input  logic [REG_AW-1:0] rtE_i,
   output logic [REG_AW-1:0] writeregM_o,
   output logic              regwriteM_o,
   output logic [DATA_W-1:0] aluoutM_o,
   output logic [REG_AW-1:0] writeregW_o,
   output logic              regwriteW_o,
   output logic [DATA_W-1:0] resultW_o,
   output logic [1:0]        forwardAE_o,
   output logic [1:0]        forwardBE_o,
   output logic              forwardAD_o,
   output logic              forwardBD_o,
   output logic              lwstallD_o
);

   logic              memtoregM;
   logic              rwE_nz;     // $0 writes are dropped at M entry
   logic [DATA_W-1:0] resE;
   logic [DATA_W-1:0] resM;

   assign rwE_nz = regwriteE_i && (writeregE_i != '0);
   assign resE   = linkE_i ? pcplus8E_i : aluoutE_i;
   assign resM   = memtoregM ? readdataM_i : aluoutM_o;

   // E -> M
   pipe_reg #(.W(REG_AW)) u_wrM (.clk_i, .rst_i, .flush_i(flushM_i), .stall_i(stallM_i),
                                 .d_i(writeregE_i), .q_o(writeregM_o));
   pipe_reg #(.W(1))      u_rwM (.clk_i, .rst_i, .flush_i(flushM_i), .stall_i(stallM_i),
                                 .d_i(rwE_nz), .q_o(regwriteM_o));
   pipe_reg #(.W(1))      u_mtM (.clk_i, .rst_i, .flush_i(flushM_i), .stall_i(stallM_i),
                                 .d_i(memtoregE_i), .q_o(memtoregM));
   pipe_reg #(.W(DATA_W)) u_alM (.clk_i, .rst_i, .flush_i(flushM_i), .stall_i(stallM_i),
                                 .d_i(resE), .q_o(aluoutM_o));

   // M -> W
   pipe_reg #(.W(REG_AW)) u_wrW (.clk_i, .rst_i, .flush_i(flushW_i), .stall_i(stallW_i),
                                 .d_i(writeregM_o), .q_o(writeregW_o));
   pipe_reg #(.W(1))      u_rwW (.clk_i, .rst_i, .flush_i(flushW_i), .stall_i(stallW_i),
                                 .d_i(regwriteM_o), .q_o(regwriteW_o));
   pipe_reg #(.W(DATA_W)) u_reW (.clk_i, .rst_i, .flush_i(flushW_i), .stall_i(stallW_i),
                                 .d_i(resM), .q_o(resultW_o));

   // Forwarding and load-use detection; $0 never matches.
   logic m_live, w_live;
   assign m_live = regwriteM_o && (writeregM_o != '0);
   assign w_live = regwriteW_o && (writeregW_o != '0);

   always_comb begin
      forwardAE_o = FWD_RF;
      forwardBE_o = FWD_RF;
      if (m_live && writeregM_o == rsE_i)      forwardAE_o = FWD_M;
      else if (w_live && writeregW_o == rsE_i) forwardAE_o = FWD_W;
      if (m_live && writeregM_o == rtE_i)      forwardBE_o = FWD_M;
      else if (w_live && writeregW_o == rtE_i) forwardBE_o = FWD_W;
   end

   assign forwardAD_o = m_live && (writeregM_o == rsD_i);
   assign forwardBD_o = m_live && (writeregM_o == rtD_i);
   assign lwstallD_o  = memtoregE_i && rwE_nz &&
                        ((writeregE_i == rsD_i) || (writeregE_i == rtD_i));

endmodule

// File: tb/tb_dest_wb_pipe.sv
module tb_dest_wb_pipe;

   logic        clk = 0;
   logic        rst, stallM, flushM, stallW, flushW;
   logic [4:0]  writeregE, rsD, rtD, rsE, rtE;
   logic        regwriteE, memtoregE, linkE;
   logic [31:0] aluoutE, pcplus8E, readdataM;
   logic [4:0]  writeregM, writeregW;
   logic        regwriteM, regwriteW, forwardAD, forwardBD, lwstallD;
   logic [31:0] aluoutM, resultW;
   logic [1:0]  forwardAE, forwardBE;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 0;

   always #5 clk = ~clk;

   dest_wb_pipe dut (
      .clk_i(clk), .rst_i(rst), .stallM_i(stallM), .flushM_i(flushM),
      .stallW_i(stallW), .flushW_i(flushW), .writeregE_i(writeregE),
      .regwriteE_i(regwriteE), .memtoregE_i(memtoregE), .linkE_i(linkE),
      .aluoutE_i(aluoutE), .pcplus8E_i(pcplus8E), .readdataM_i(readdataM),
      .rsD_i(rsD), .rtD_i(rtD), .rsE_i(rsE), .rtE_i(rtE),
      .writeregM_o(writeregM), .regwriteM_o(regwriteM), .aluoutM_o(aluoutM),
      .writeregW_o(writeregW), .regwriteW_o(regwriteW), .resultW_o(resultW),
      .forwardAE_o(forwardAE), .forwardBE_o(forwardBE),
      .forwardAD_o(forwardAD), .forwardBD_o(forwardBD), .lwstallD_o(lwstallD)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each stage holds the tuple an instruction carries: destination,
   // write enable, is-load, and its value.
   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic        ld;
      logic [31:0] val;
   } slot_t;

   slot_t mM, mW;

   function automatic logic [1:0] m_fwd(input logic [4:0] r);
      if (mM.we && mM.rd != 0 && mM.rd == r) return 2'b10;
      if (mW.we && mW.rd != 0 && mW.rd == r) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk) begin
      slot_t nm, nw;
      nm = mM;
      nw = mW;
      if (!stallW) begin
         nw = mM;
         nw.val = mM.ld ? readdataM : mM.val;
         nw.ld  = 1'b0;
      end
      if (flushW) nw = '{0, 0, 0, 0};
      if (!stallM) begin
         nm.rd  = writeregE;
         nm.we  = regwriteE && writeregE != 0;
         nm.ld  = memtoregE;
         nm.val = linkE ? pcplus8E : aluoutE;
      end
      if (flushM) nm = '{0, 0, 0, 0};
      if (rst) begin
         nm = '{0, 0, 0, 0};
         nw = '{0, 0, 0, 0};
      end
      mM = nm;
      mW = nw;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("writeregM", writeregM, mM.rd);
         check("regwriteM", regwriteM, mM.we);
         check("aluoutM",   aluoutM,   mM.val);
         check("writeregW", writeregW, mW.rd);
         check("regwriteW", regwriteW, mW.we);
         check("resultW",   resultW,   mW.val);
         check("forwardAE", forwardAE, m_fwd(rsE));
         check("forwardBE", forwardBE, m_fwd(rtE));
         check("forwardAD", forwardAD, m_fwd(rsD) == 2'b10);
         check("forwardBD", forwardBD, m_fwd(rtD) == 2'b10);
         check("lwstallD",  lwstallD,
               memtoregE && regwriteE && writeregE != 0 &&
               (writeregE == rsD || writeregE == rtD));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      stallM = 0; flushM = 0; stallW = 0; flushW = 0;
      writeregE = 0; regwriteE = 0; memtoregE = 0; linkE = 0;
      aluoutE = 0; pcplus8E = 0; readdataM = 0;
      rsD = 0; rtD = 0; rsE = 0; rtE = 0;
   endtask

   task automatic setE(input logic [4:0] rd, input logic we, input logic ld,
                       input logic [31:0] alu);
      writeregE = rd; regwriteE = we; memtoregE = ld; aluoutE = alu;
   endtask

   initial begin
      idle();
      // reset with random inputs
      rst = 1;
      writeregE = 5'($urandom); regwriteE = 1'($urandom); memtoregE = 0;
      linkE = 1'($urandom); aluoutE = $urandom; pcplus8E = $urandom;
      readdataM = $urandom; rsE = 5'($urandom); rtE = 5'($urandom);
      stallM = 1'($urandom); stallW = 1'($urandom);
      tick();
      chk_en = 1;
      tick();
      rst = 0;
      idle();
      #2;
      check("rst writeregM", writeregM, 0);
      check("rst regwriteM", regwriteM, 0);
      check("rst aluoutM",   aluoutM,   0);
      check("rst writeregW", writeregW, 0);
      check("rst regwriteW", regwriteW, 0);
      check("rst resultW",   resultW,   0);
      check("rst forwardAE", forwardAE, 0);

      // JALR link: result is the link address, not the ALU output
      setE(31, 1, 0, 32'hDEAD); linkE = 1; pcplus8E = 32'h0040_0010;
      tick(); idle(); #2;
      check("link aluoutM", aluoutM, 32'h0040_0010);
      tick(); #2;
      check("link regwriteW", regwriteW, 1);
      check("link writeregW", writeregW, 31);
      check("link resultW",   resultW,   32'h0040_0010);

      // load-use
      setE(8, 1, 1, 32'h100); rsD = 8; #2;
      check("lw lwstallD", lwstallD, 1);
      tick(); idle(); readdataM = 32'h1234; #2;
      check("lw lwstallD bubble", lwstallD, 0);
      tick(); readdataM = 0; #2;
      check("lw resultW",   resultW,   32'h1234);
      check("lw writeregW", writeregW, 8);
      // same load via rtD
      setE(8, 1, 1, 0); rtD = 8; #2;
      check("lw lwstallD rt", lwstallD, 1);
      tick(); idle();

      // forward priority: M over W, then W only after flushM
      setE(5, 1, 0, 32'h22); tick();
      setE(5, 1, 0, 32'h11); tick();
      idle(); rsE = 5; rtE = 5; rsD = 5; rtD = 5; #2;
      check("fwd aluoutM",   aluoutM,   32'h11);
      check("fwd resultW",   resultW,   32'h22);
      check("fwd AE M",      forwardAE, 2'b10);
      check("fwd BE M",      forwardBE, 2'b10);
      check("fwd AD",        forwardAD, 1);
      check("fwd BD",        forwardBD, 1);
      flushM = 1; tick(); flushM = 0; #2;
      check("fwd AE W",      forwardAE, 2'b01);
      check("fwd AD off",    forwardAD, 0);
      tick(); idle();

      // $0 suppression
      setE(0, 1, 0, 32'h55); rsE = 0; rsD = 0; tick();
      setE(0, 0, 0, 0); #2;
      check("r0 regwriteM", regwriteM, 0);
      check("r0 forwardAE", forwardAE, 2'b00);
      check("r0 forwardAD", forwardAD, 0);
      tick(); #2;
      check("r0 regwriteW", regwriteW, 0);
      idle();

      // stall/flush mix
      setE(9, 1, 0, 32'h99); tick();
      setE(12, 1, 0, 32'hCC); stallM = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); #2;
         check("stallM writeregM", writeregM, 9);
      end
      flushM = 1; tick(); #2;
      check("flush>stall writeregM", writeregM, 0);
      check("flush>stall regwriteM", regwriteM, 0);
      idle();

      // W stall holds, W flush beats stall
      setE(7, 1, 0, 32'h77); tick(); idle(); tick();
      stallW = 1; setE(3, 1, 0, 32'h33); tick(); tick(); #2;
      check("stallW writeregW", writeregW, 7);
      check("stallW resultW",   resultW,   32'h77);
      flushW = 1; tick(); #2;
      check("flushW regwriteW", regwriteW, 0);
      idle(); tick(); tick();

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
